// File: rtl/spike_pkg.sv
// Shared types and constants for the spike rate decoder and its neighbouring neuron blocks.
package spike_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Width of the neuron current bus; the rate count matches it by default.
  localparam int unsigned CURRENT_W      = 5;
  localparam int unsigned DEFAULT_WINDOW = 32;
  localparam int unsigned DEFAULT_ISI_W  = 8;

  // Width of a counter that runs 0..window-1.
  function automatic int unsigned win_width(input int unsigned window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: valid/ready handshake plus data and sticky overflow.
interface spike_rate_decoder_if
  import spike_pkg::*;
#(
  parameter int unsigned CNT_W = CURRENT_W,
  parameter int unsigned ISI_W = DEFAULT_ISI_W
);

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count_out;
  logic [ISI_W-1:0] isi_out;
  logic             overflow;

  modport master (
    output out_valid,
    output count_out,
    output isi_out,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  count_out,
    input  isi_out,
    input  overflow,
    output out_ready
  );

endinterface

// File: rtl/spike_sat_counter.sv
// Saturating up-counter with clear and load-one; value_inc is the saturated increment of the
// current value, ignoring clear/load, so callers can capture the count including this cycle.
module spike_sat_counter
  import spike_pkg::*;
#(
  parameter int unsigned WIDTH = CURRENT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_inc
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_inc = value_q;
    if (inc && (value_q != MaxVal)) begin
      value_inc = value_q + 1'b1;
    end
  end

  // Clear wins over load-one, which wins over increment.
  always_comb begin
    value_d = value_inc;
    if (load_one) begin
      value_d = WIDTH'(1);
    end
    if (clear) begin
      value_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train to rate (count per window) and timing (last ISI) decoder with valid/ready output.
// Optional: define SPIKE_RATE_DECODER_EDGE_EN to count rising edges instead of high cycles.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WINDOW = DEFAULT_WINDOW,
  parameter int unsigned CNT_W  = CURRENT_W,
  parameter int unsigned ISI_W  = DEFAULT_ISI_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        spike_in,
  spike_rate_decoder_if.master        result
);

  localparam int unsigned      WinW    = win_width(WINDOW);
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);

  state_e           state_q;
  logic [WinW-1:0]  win_q;
  logic             seen_q;
  logic [ISI_W-1:0] last_isi_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] count_out_q;
  logic [ISI_W-1:0] isi_out_q;
  logic             overflow_q;

  logic             spike_event;
  logic             win_end;
  logic             xfer;
  logic [CNT_W-1:0] cnt_now;
  logic [CNT_W-1:0] cnt_value_unused;
  logic [ISI_W-1:0] isi_timer;
  logic [ISI_W-1:0] isi_timer_inc_unused;
  logic [ISI_W-1:0] isi_now;

`ifdef SPIKE_RATE_DECODER_EDGE_EN
  logic spike_in_q;

  // Previous sample is forced low while idle so a level already high at enable counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_in_q <= 1'b0;
    end else begin
      spike_in_q <= enable ? spike_in : 1'b0;
    end
  end

  assign spike_event = enable & spike_in & ~spike_in_q;
`else
  assign spike_event = enable & spike_in;
`endif

  assign win_end = enable && (win_q == WinLast);
  assign xfer    = out_valid_q && result.out_ready;

  spike_sat_counter #(
    .WIDTH (CNT_W)
  ) u_spike_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (!enable || win_end),
    .load_one  (1'b0),
    .inc       (spike_event),
    .value     (cnt_value_unused),
    .value_inc (cnt_now)
  );

  spike_sat_counter #(
    .WIDTH (ISI_W)
  ) u_isi_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (!enable),
    .load_one  (spike_event),
    .inc       (enable),
    .value     (isi_timer),
    .value_inc (isi_timer_inc_unused)
  );

  // ISI as it stands including a spike on this very cycle.
  assign isi_now = (spike_event && seen_q) ? isi_timer : last_isi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      seen_q      <= 1'b0;
      last_isi_q  <= '0;
      out_valid_q <= 1'b0;
      count_out_q <= '0;
      isi_out_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= COUNT;
            win_q   <= WinW'(1);
          end else begin
            win_q   <= '0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state_q <= IDLE;
            win_q   <= '0;
          end else begin
            win_q   <= win_end ? '0 : win_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          win_q   <= '0;
        end
      endcase

      if (!enable) begin
        seen_q     <= 1'b0;
        last_isi_q <= '0;
      end else if (spike_event) begin
        seen_q     <= 1'b1;
        last_isi_q <= isi_now;
      end

      if (xfer) begin
        out_valid_q <= 1'b0;
      end
      if (win_end) begin
        if (!out_valid_q || result.out_ready) begin
          out_valid_q <= 1'b1;
          count_out_q <= cnt_now;
          isi_out_q   <= isi_now;
        end else begin
          overflow_q  <= 1'b1;
        end
      end
    end
  end

  assign result.out_valid = out_valid_q;
  assign result.count_out = count_out_q;
  assign result.isi_out   = isi_out_q;
  assign result.overflow  = overflow_q;

endmodule
